// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite compositor: transparent key colour,
// screen limits and the 24-bit colour type.
package sprite_pkg;

  typedef logic [23:0] rgb24;

  localparam rgb24 KEY_RGB_DEFAULT = 24'hEE35FF;
  localparam int   SCREEN_W        = 640;
  localparam int   SCREEN_H        = 480;

endpackage

// File: rtl/sprite_channel.sv
// One sprite channel: animation counters, hit test and registered ROM address.
// Horizontal mirroring exists only when SPRITE_HFLIP_EN is defined.
module sprite_channel
  import sprite_pkg::*;
#(
  parameter int SPR_SIZE    = 16,
  parameter int NUM_FRAMES  = 4,
  parameter int FRAME_TICKS = 6,
  parameter int AW          = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          tick_i,
  input  logic [9:0]    draw_x_i,
  input  logic [9:0]    draw_y_i,
  input  logic [9:0]    spr_x_i,
  input  logic [9:0]    spr_y_i,
  input  logic          en_i,
  input  logic          anim_i,
  input  logic          flip_i,
  output logic [AW-1:0] rom_addr_o,
  output logic          hit_o
);

  localparam int SW  = $clog2(SPR_SIZE);
  localparam int FW  = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int TW  = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int PIX = SPR_SIZE * SPR_SIZE;

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [AW-1:0] rom_addr_p0_q, rom_addr_d;
  logic          hit_p0_q, hit_d;

  // Counters sit at zero while animation is off, so a rising anim restarts at frame 0.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    frame_d    = frame_q;
    if (!anim_i) begin
      tick_cnt_d = '0;
      frame_d    = '0;
    end else if (tick_i) begin
      if (tick_cnt_q == TW'(FRAME_TICKS - 1)) begin
        tick_cnt_d = '0;
        frame_d    = (frame_q == FW'(NUM_FRAMES - 1)) ? '0 : frame_q + 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + 1'b1;
      end
    end
  end

  logic [10:0] x11, y11, sx11, sy11;
  logic [9:0]  dx, dy;
  logic [SW-1:0] col, row;

  assign x11  = {1'b0, draw_x_i};
  assign y11  = {1'b0, draw_y_i};
  assign sx11 = {1'b0, spr_x_i};
  assign sy11 = {1'b0, spr_y_i};

  assign hit_d = en_i
              && (x11 >= sx11) && (x11 < sx11 + 11'(SPR_SIZE))
              && (y11 >= sy11) && (y11 < sy11 + 11'(SPR_SIZE));

  assign dx  = draw_x_i - spr_x_i;
  assign dy  = draw_y_i - spr_y_i;
  assign row = dy[SW-1:0];

`ifdef SPRITE_HFLIP_EN
  assign col = flip_i ? ~dx[SW-1:0] : dx[SW-1:0];
`else
  assign col = dx[SW-1:0];
  logic unused_flip;
  assign unused_flip = flip_i;
`endif

  logic unused_hi;
  assign unused_hi = ^{dx[9:SW], dy[9:SW]};

  assign rom_addr_d = AW'(32'(frame_q) * 32'(PIX) + 32'(row) * 32'(SPR_SIZE) + 32'(col));

  // Stage 0 -> 1 boundary: address and hit registered together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tick_cnt_q    <= '0;
      frame_q       <= '0;
      rom_addr_p0_q <= '0;
      hit_p0_q      <= 1'b0;
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      frame_q       <= frame_d;
      rom_addr_p0_q <= rom_addr_d;
      hit_p0_q      <= hit_d;
    end
  end

  assign rom_addr_o = rom_addr_p0_q;
  assign hit_o      = hit_p0_q;

endmodule

// File: rtl/sprite_compositor.sv
// Multi-channel sprite compositor: 3-cycle pixel pipeline over synchronous ROMs.
// Define SPRITE_HFLIP_EN to enable per-channel horizontal mirroring.
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int   NUM_SPRITES = 4,
  parameter int   SPR_SIZE    = 16,
  parameter int   NUM_FRAMES  = 4,
  parameter int   FRAME_TICKS = 6,
  parameter rgb24 KEY_RGB     = KEY_RGB_DEFAULT,
  localparam int  AW          = $clog2(NUM_FRAMES * SPR_SIZE * SPR_SIZE)
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic                             frame_clk,
  input  logic                             blank,
  input  logic [9:0]                       DrawX,
  input  logic [9:0]                       DrawY,
  input  logic [NUM_SPRITES-1:0][9:0]      spr_x,
  input  logic [NUM_SPRITES-1:0][9:0]      spr_y,
  input  logic [NUM_SPRITES-1:0]           spr_en,
  input  logic [NUM_SPRITES-1:0]           spr_anim,
  input  logic [NUM_SPRITES-1:0]           spr_flip,
  output logic [NUM_SPRITES-1:0][AW-1:0]   rom_addr,
  input  logic [NUM_SPRITES-1:0][23:0]     rom_data,
  input  logic [23:0]                      bg_rgb,
  output logic [7:0]                       Red,
  output logic [7:0]                       Green,
  output logic [7:0]                       Blue
);

  // Two synchroniser flops plus one history flop for rising-edge detection.
  logic [2:0] fsync_q;
  logic       tick;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) fsync_q <= '0;
    else       fsync_q <= {fsync_q[1:0], frame_clk};
  end

  assign tick = fsync_q[1] & ~fsync_q[2];

  logic [NUM_SPRITES-1:0] hit_p0;

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_chan
    sprite_channel #(
      .SPR_SIZE    (SPR_SIZE),
      .NUM_FRAMES  (NUM_FRAMES),
      .FRAME_TICKS (FRAME_TICKS),
      .AW          (AW)
    ) u_chan (
      .clk_i      (Clk),
      .rst_i      (Reset),
      .tick_i     (tick),
      .draw_x_i   (DrawX),
      .draw_y_i   (DrawY),
      .spr_x_i    (spr_x[g]),
      .spr_y_i    (spr_y[g]),
      .en_i       (spr_en[g]),
      .anim_i     (spr_anim[g]),
      .flip_i     (spr_flip[g]),
      .rom_addr_o (rom_addr[g]),
      .hit_o      (hit_p0[g])
    );
  end

  logic                   blank_p0_q, blank_p1_q;
  logic [NUM_SPRITES-1:0] hit_p1_q;
  rgb24                   bg_p1_q;
  rgb24                   rgb_p2_q, rgb_d;

  // Stage 1 -> 2 boundary: hit/blank/background aligned with the ROM read data.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      blank_p0_q <= 1'b0;
      blank_p1_q <= 1'b0;
      hit_p1_q   <= '0;
    end else begin
      blank_p0_q <= blank;
      blank_p1_q <= blank_p0_q;
      hit_p1_q   <= hit_p0;
    end
  end

  always_ff @(posedge Clk) begin
    bg_p1_q <= bg_rgb;
  end

  // Descending scan so the lowest-index opaque channel is the final winner.
  always_comb begin
    rgb_d = bg_p1_q;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit_p1_q[i] && (rom_data[i] != KEY_RGB)) rgb_d = rom_data[i];
    end
    if (!blank_p1_q) rgb_d = '0;
  end

  // Stage 2 output register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) rgb_p2_q <= '0;
    else       rgb_p2_q <= rgb_d;
  end

  assign Red   = rgb_p2_q[23:16];
  assign Green = rgb_p2_q[15:8];
  assign Blue  = rgb_p2_q[7:0];

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor with a synchronous ROM model whose word
// encodes {channel+1, addr}, so expected colours follow directly from addresses.
module tb_sprite_compositor;

  localparam int NS = 4;
  localparam int AW = 10;
  localparam logic [23:0] BG  = 24'h123456;
  localparam logic [23:0] KEY = 24'hEE35FF;

  logic                  Clk = 1'b0;
  logic                  Reset;
  logic                  frame_clk;
  logic                  blank;
  logic [9:0]            DrawX, DrawY;
  logic [NS-1:0][9:0]    spr_x, spr_y;
  logic [NS-1:0]         spr_en, spr_anim, spr_flip;
  logic [NS-1:0][AW-1:0] rom_addr;
  logic [NS-1:0][23:0]   rom_data;
  logic [23:0]           bg_rgb;
  logic [7:0]            Red, Green, Blue;
  logic [NS-1:0]         key_ch;
  logic [23:0]           rgb;

  int checks = 0;
  int errors = 0;

  sprite_compositor dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .blank     (blank),
    .DrawX     (DrawX),
    .DrawY     (DrawY),
    .spr_x     (spr_x),
    .spr_y     (spr_y),
    .spr_en    (spr_en),
    .spr_anim  (spr_anim),
    .spr_flip  (spr_flip),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .bg_rgb    (bg_rgb),
    .Red       (Red),
    .Green     (Green),
    .Blue      (Blue)
  );

  always #5 Clk = ~Clk;

  assign rgb = {Red, Green, Blue};

  always @(posedge Clk) begin
    for (int i = 0; i < NS; i++)
      rom_data[i] <= key_ch[i] ? KEY : {4'(i + 1), 10'd0, rom_addr[i]};
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // One pixel for one cycle, then an off-sprite pixel; output checked 3 edges later.
  task automatic pix(input string tag, input logic [9:0] x, input logic [9:0] y,
                     input logic bl, input logic [23:0] exp);
    @(negedge Clk);
    DrawX = x; DrawY = y; blank = bl;
    @(posedge Clk);
    @(negedge Clk);
    DrawX = 10'd0; DrawY = 10'd0; blank = 1'b1;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    check_eq(tag, 32'(rgb), 32'(exp));
  endtask

  task automatic pulse();
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; frame_clk = 1'b0; blank = 1'b1;
    DrawX = '0; DrawY = '0; bg_rgb = BG; key_ch = '0;
    spr_en = '0; spr_anim = '0; spr_flip = '0;
    spr_x[0] = 10'd100; spr_y[0] = 10'd50;
    spr_x[1] = 10'd104; spr_y[1] = 10'd52;
    spr_x[2] = 10'd630; spr_y[2] = 10'd200;
    spr_x[3] = 10'd300; spr_y[3] = 10'd300;

    repeat (2) @(posedge Clk);
    #1;
    check_eq("reset_rgb", 32'(rgb), 32'h0);
    check_eq("reset_addr", 32'(rom_addr[0]), 32'h0);
    @(negedge Clk);
    Reset = 1'b0;

    spr_en = 4'b0001;
    pix("spr0_origin",  10'd100, 10'd50, 1'b1, 24'h100000);
    pix("spr0_right",   10'd116, 10'd50, 1'b1, BG);
    pix("spr0_inner",   10'd103, 10'd52, 1'b1, 24'h100023);
    pix("spr0_corner",  10'd115, 10'd65, 1'b1, 24'h1000FF);
    pix("spr0_above",   10'd100, 10'd49, 1'b1, BG);

    spr_en = 4'b0011;
    pix("overlap_ch0",  10'd106, 10'd55, 1'b1, 24'h100056);
    key_ch = 4'b0001;
    pix("overlap_key",  10'd106, 10'd55, 1'b1, 24'h200032);
    key_ch = 4'b0000;

    spr_en = 4'b0100;
    pix("edge_hit",     10'd635, 10'd201, 1'b1, 24'h300015);
    pix("edge_nowrap",  10'd5,   10'd201, 1'b1, BG);

    spr_en = 4'b0001;
    pix("blank_opaque", 10'd100, 10'd50, 1'b0, 24'h000000);

    @(negedge Clk);
    spr_flip = 4'b0001; DrawX = 10'd100; DrawY = 10'd50;
    @(negedge Clk);
`ifdef SPRITE_HFLIP_EN
    check_eq("flip_col", 32'(rom_addr[0]), 32'd15);
`else
    check_eq("flip_col", 32'(rom_addr[0]), 32'd0);
`endif
    spr_flip = 4'b0000;

    spr_anim = 4'b0001;
    repeat (2) @(negedge Clk);
    check_eq("anim_start", 32'(rom_addr[0][9:8]), 32'd0);
    for (int k = 1; k <= 24; k++) begin
      pulse();
      check_eq($sformatf("anim_tick%0d", k), 32'(rom_addr[0][9:8]), 32'((k / 6) % 4));
    end

    spr_anim = 4'b0000;
    repeat (2) @(negedge Clk);
    check_eq("anim_off", 32'(rom_addr[0][9:8]), 32'd0);
    repeat (7) pulse();
    check_eq("anim_off_hold", 32'(rom_addr[0][9:8]), 32'd0);
    spr_anim = 4'b0001;
    repeat (6) pulse();
    check_eq("anim_restart", 32'(rom_addr[0][9:8]), 32'd1);
    repeat (6) pulse();
    check_eq("pre_reset_frame", 32'(rom_addr[0][9:8]), 32'd2);

    DrawX = 10'd101;
    repeat (4) @(negedge Clk);
    check_eq("pre_reset_rgb", 32'(rgb), 32'h100201);
    @(posedge Clk);
    #2 Reset = 1'b1;
    #1;
    check_eq("async_rst_rgb", 32'(rgb), 32'h0);
    check_eq("async_rst_addr", 32'(rom_addr[0]), 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (4) @(negedge Clk);
    check_eq("post_reset_addr", 32'(rom_addr[0]), 32'd1);
    check_eq("post_reset_rgb", 32'(rgb), 32'h100001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_compositor.md
SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 SHALL take parameter NUM_SPRITES, default 4: number of independent sprite channels.
REQ-002 SHALL take parameter SPR_SIZE, default 16: sprite edge in pixels; power of two.
REQ-003 SHALL take parameter NUM_FRAMES, default 4: animation frames per sprite ROM.
REQ-004 SHALL take parameter FRAME_TICKS, default 6: frame_clk ticks per animation step; at least 1.
REQ-005 SHALL take parameter KEY_RGB, default 24'hEE35FF: transparent colour.
REQ-006 SHALL have ports in this order:
- Clk  in  1  pixel-domain clock; one clock; reset is asynchronous and active-high.
- Reset  in  1  asynchronous, active-high.
- frame_clk  in  1  vertical-sync strobe, asynchronous to Clk.
- blank  in  1  1 = active video.
- DrawX, DrawY  in  10 each  current pixel.
- spr_x, spr_y  in  NUM_SPRITES x 10  top-left of each sprite.
- spr_en  in  NUM_SPRITES  channel visible.
- spr_anim  in  NUM_SPRITES  1 = cycle frames, 0 = hold frame 0.
- spr_flip  in  NUM_SPRITES  horizontal mirror.
- rom_addr  out  NUM_SPRITES x AW  per-channel ROM address; AW = clog2(NUM_FRAMES*SPR_SIZE*SPR_SIZE).
- rom_data  in  NUM_SPRITES x 24  synchronous ROM data, one-cycle read latency.
- bg_rgb  in  24  background colour, valid one cycle after its DrawX/DrawY.
- Red, Green, Blue  out  8 each  composited pixel.

Function
REQ-007 SHALL synchronise frame_clk through two flops and generate a one-cycle tick on its rising edge.
REQ-008 SHALL keep per-channel tick counter 0..FRAME_TICKS-1 and frame index 0..NUM_FRAMES-1; on each tick the tick counter increments, and on wrap the frame index increments, wrapping NUM_FRAMES-1 -> 0.
REQ-009 SHALL hold both counters of a channel at 0 while its spr_anim=0; on spr_anim rising edge, animation restarts from frame 0.
REQ-010 SHALL compute stage 0 per channel: hit = spr_en and DrawX in [spr_x, spr_x+SPR_SIZE) and DrawY in [spr_y, spr_y+SPR_SIZE), using 11-bit compares so sprite edges beyond 639/479 never wrap.
REQ-011 SHALL form rom_addr = frame*SPR_SIZE^2 + row*SPR_SIZE + col, where col = DrawX-spr_x, or SPR_SIZE-1-col when mirrored; rom_addr registered.
REQ-012 SHALL pipeline hit and blank alongside the ROM read; stage 1 aligns rom_data, bg_rgb, hit and blank.
REQ-013 SHALL in stage 2 select the lowest-index channel whose hit=1 and rom_data != KEY_RGB, else bg_rgb; registered into Red/Green/Blue.
REQ-014 SHALL drive RGB 0 when the aligned blank=0.
REQ-015 SHALL have total latency of 3 Clk cycles from DrawX/DrawY to RGB.
REQ-016 SHALL, when a tick coincides with a pixel, use the new frame index from the next cycle's address onward; no pixel mixes two frames.
REQ-017 SHALL ignore spr_x/spr_y changes mid-pixel-pipeline; each stage uses values captured at stage 0.

Reset
REQ-018 SHALL on Reset clear rom_addr, Red, Green, Blue, pipeline hit/blank, all counters, sync flops to 0, immediately and asynchronously.
REQ-019 SHALL after Reset deassertion output valid pixels from the third Clk edge; no tick is generated from the sync flops' reset state.

Configuration
REQ-020 SHALL compile mirroring only with macro SPRITE_HFLIP_EN defined; without it spr_flip is unused and col is never mirrored.

Structure
REQ-021 SHALL place KEY_RGB default, screen limits 640/480 and the rgb24 typedef in shared package sprite_pkg.
REQ-022 SHALL implement per-channel counters and address generation in sub-module sprite_channel, instantiated NUM_SPRITES times via generate.

Verification
REQ-023 SHALL cover: sprite0 at (100,50), ROM pixel non-key, DrawX=100,DrawY=50 -> sprite RGB 3 cycles later; DrawX=116 -> bg_rgb.
REQ-024 SHALL cover: channels 0 and 1 overlapping, both opaque -> channel 0 colour; channel 0 key colour -> channel 1 colour.
REQ-025 SHALL cover: FRAME_TICKS=6, NUM_FRAMES=4, 24 frame_clk pulses -> frame sequence 0,1,2,3,0 each lasting 6 ticks; spr_anim=0 -> rom_addr frame field 0.
REQ-026 SHALL cover: spr_x=630, DrawX=5 -> no hit; blank=0 over an opaque sprite -> RGB 0.
REQ-027 SHALL cover: SPRITE_HFLIP_EN defined, spr_flip=1, col 0 -> rom_addr column 15; undefined -> column 0.
REQ-028 SHALL cover: Reset asserted mid-line with frame index 2 -> outputs and counters 0 within the same cycle, frame 0 after release.
